// File: rtl/hc4_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : hc4_ram_arbiter
//  Purpose  : Two-port arbiter and strobe sequencer for the HC4 external RAM
//             bus (8-bit address, 4-bit data). Port 0 is the CPU core, port 1
//             a secondary master (loader / debug / DMA). Generates registered
//             nRAM_RD / nRAM_WR strobes with programmable setup, strobe and
//             hold lengths and returns a one-cycle ack to the winner.
//  Ports    : clk, rst                  - clock, async active-high reset
//             p{0,1}_req/we/addr/wdata  - requester inputs (held until ack)
//             p{0,1}_rdata, p{0,1}_ack  - read data (held), completion pulse
//             grant, busy               - current owner (one-hot), not idle
//             ram_addr, ram_dq_out,
//             ram_dq_oe, ram_dq_in      - RAM address / data bus
//             nRAM_RD, nRAM_WR          - active-low strobes
//  Revision : 1.0 - initial release
// ============================================================================
module hc4_ram_arbiter #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int FIXED_PRI  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       p0_req,
  input  logic       p0_we,
  input  logic [7:0] p0_addr,
  input  logic [3:0] p0_wdata,
  output logic [3:0] p0_rdata,
  output logic       p0_ack,
  input  logic       p1_req,
  input  logic       p1_we,
  input  logic [7:0] p1_addr,
  input  logic [3:0] p1_wdata,
  output logic [3:0] p1_rdata,
  output logic       p1_ack,
  output logic [1:0] grant,
  output logic       busy,
  output logic [7:0] ram_addr,
  output logic [3:0] ram_dq_out,
  output logic       ram_dq_oe,
  input  logic [3:0] ram_dq_in,
  output logic       nRAM_RD,
  output logic       nRAM_WR
);

  // A strobe length of zero would never assert the strobe, so it is bumped to 1.
  localparam logic [2:0] SETUP_LEN  = 3'(SETUP_CYC);
  localparam logic [2:0] STROBE_LEN = (STROBE_CYC == 0) ? 3'd1 : 3'(STROBE_CYC);
  localparam logic [2:0] HOLD_LEN   = 3'(HOLD_CYC);
  localparam bit         FIXED      = (FIXED_PRI != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_ACK    = 3'd4
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] cnt;
  logic [2:0] cnt_nxt;
  logic       cur_we;
  logic       we_nxt;
  logic       last_grant;   // 1 = port 1 owned the previous transaction
  logic       win1;         // arbitration result: 1 = port 1 wins
  logic       start;        // a transaction is granted on this edge
  logic       strobing_nxt;
  logic       active_nxt;

  // Arbitration. Only meaningful when at least one request is present.
  always_comb begin
    win1 = 1'b0;
    if (FIXED) begin
      win1 = !p0_req;
    end else if (p0_req && p1_req) begin
      win1 = !last_grant;
    end else begin
      win1 = !p0_req;
    end
  end

  // Next-state logic; the down-counter is loaded with length-1 on entry to
  // each timed phase and the phase ends when it reads zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start     = 1'b0;
    case (state)
      S_IDLE: begin
        if (p0_req || p1_req) begin
          start = 1'b1;
          if (SETUP_LEN == 3'd0) begin
            state_nxt = S_STROBE;
            cnt_nxt   = STROBE_LEN - 3'd1;
          end else begin
            state_nxt = S_SETUP;
            cnt_nxt   = SETUP_LEN - 3'd1;
          end
        end
      end
      S_SETUP: begin
        if (cnt == 3'd0) begin
          state_nxt = S_STROBE;
          cnt_nxt   = STROBE_LEN - 3'd1;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      S_STROBE: begin
        if (cnt == 3'd0) begin
          if (HOLD_LEN == 3'd0) begin
            state_nxt = S_ACK;
          end else begin
            state_nxt = S_HOLD;
            cnt_nxt   = HOLD_LEN - 3'd1;
          end
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      S_HOLD: begin
        if (cnt == 3'd0) begin
          state_nxt = S_ACK;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so every strobe edge
  // coincides with a clock edge and cannot glitch.
  always_comb begin
    we_nxt       = start ? (win1 ? p1_we : p0_we) : cur_we;
    strobing_nxt = (state_nxt == S_STROBE);
    active_nxt   = (state_nxt == S_SETUP) || (state_nxt == S_STROBE) ||
                   (state_nxt == S_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_we     <= 1'b0;
      last_grant <= 1'b1;
      grant      <= 2'b00;
      ram_addr   <= 8'h00;
      ram_dq_out <= 4'h0;
      ram_dq_oe  <= 1'b0;
      nRAM_RD    <= 1'b1;
      nRAM_WR    <= 1'b1;
      p0_ack     <= 1'b0;
      p1_ack     <= 1'b0;
      p0_rdata   <= 4'h0;
      p1_rdata   <= 4'h0;
    end else begin
      cur_we    <= we_nxt;
      nRAM_RD   <= !(strobing_nxt && !we_nxt);
      nRAM_WR   <= !(strobing_nxt && we_nxt);
      ram_dq_oe <= active_nxt && we_nxt;
      // grant still names the owner on the edge that enters ACK.
      p0_ack    <= (state_nxt == S_ACK) && grant[0];
      p1_ack    <= (state_nxt == S_ACK) && grant[1];
      if (start) begin
        ram_addr   <= win1 ? p1_addr : p0_addr;
        ram_dq_out <= win1 ? p1_wdata : p0_wdata;
        grant      <= win1 ? 2'b10 : 2'b01;
        last_grant <= win1;
      end else if ((state_nxt == S_ACK) || (state_nxt == S_IDLE)) begin
        grant <= 2'b00;
      end
      // Read data is taken on the edge that ends the strobe.
      if ((state == S_STROBE) && (state_nxt != S_STROBE) && !cur_we) begin
        if (grant[0]) p0_rdata <= ram_dq_in;
        if (grant[1]) p1_rdata <= ram_dq_in;
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule
`default_nettype wire
